// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, IF/ID register, stall/redirect/flush and halt-on-EBREAK-or-fault fetch stage
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] pc_nx, if_id_pc_nx, if_id_instruction_nx, fetch_count_nx;
  logic if_id_valid_nx, fetch_fault_nx, bad_pc;
  assign imem_address = {2'b00, pc[31:2]};
  assign halted = state == HALT;
  assign bad_pc = (|pc[1:0]) || (imem_address >= IMEM_WORDS);
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    if_id_pc_nx = if_id_pc;
    if_id_instruction_nx = if_id_instruction;
    if_id_valid_nx = if_id_valid;
    fetch_fault_nx = fetch_fault;
    fetch_count_nx = fetch_count;
    case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (redirect_valid) begin
          pc_nx = redirect_target;
          if_id_instruction_nx = NOP_INSTR;
          if_id_valid_nx = 1'b0;
        end else if (!stall) begin
          if (bad_pc) begin
            fetch_fault_nx = 1'b1;
            if_id_instruction_nx = NOP_INSTR;
            if_id_valid_nx = 1'b0;
            state_nx = HALT;
          end else begin
            if_id_pc_nx = pc;
            if_id_instruction_nx = imem_instruction;
            if_id_valid_nx = 1'b1;
            fetch_count_nx = fetch_count + 32'd1;
            // EBREAK parks the PC on itself so nothing past it is fetched
            state_nx = imem_instruction == EBREAK_INSTR ? DRAIN : RUN;
            pc_nx = imem_instruction == EBREAK_INSTR ? pc : pc + 32'd4;
          end
        end
      end
      DRAIN: begin
        if (redirect_valid || !stall) begin
          if_id_instruction_nx = NOP_INSTR;
          if_id_valid_nx = 1'b0;
          pc_nx = redirect_valid ? redirect_target : pc;
          state_nx = redirect_valid ? RUN : HALT;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc <= RESET_PC;
      if_id_pc <= 32'd0;
      if_id_instruction <= NOP_INSTR;
      if_id_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      if_id_pc <= if_id_pc_nx;
      if_id_instruction <= if_id_instruction_nx;
      if_id_valid <= if_id_valid_nx;
      fetch_fault <= fetch_fault_nx;
      fetch_count <= fetch_count_nx;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plus random stimulus, reference model feeding a scoreboard queue
module tb_instruction_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  logic clk = 1'b0;
  logic reset = 1'b1, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] imem_address, imem_instruction, pc, if_id_pc, if_id_instruction, fetch_count;
  logic if_id_valid, halted, fetch_fault;
  logic [31:0] mem [0:127];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign imem_instruction = imem_address < 32'd128 ? mem[imem_address[6:0]] : 32'd0;
  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_address(imem_address),
    .imem_instruction(imem_instruction), .pc(pc), .if_id_pc(if_id_pc),
    .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );
  typedef struct {
    logic [31:0] pc, ipc, ins, cnt;
    logic v, h, f;
  } snap_t;
  snap_t q[$];
  // reference model: architectural state only; phase 0 boot, 1 fetching, 2 EBREAK waiting for decode, 3 stopped
  logic [31:0] m_pc, m_ipc, m_ins, m_cnt;
  logic m_v, m_f;
  int m_phase;
  task automatic model_edge(input logic r, input logic s, input logic rv, input logic [31:0] rt);
    logic [31:0] w;
    if (r) begin
      m_pc = 0; m_ipc = 0; m_ins = NOP; m_v = 0; m_f = 0; m_cnt = 0; m_phase = 0;
    end else if (m_phase == 0) m_phase = 1;
    else if (m_phase == 2) begin
      if (rv) begin m_ins = NOP; m_v = 0; m_pc = rt; m_phase = 1; end
      else if (!s) begin m_ins = NOP; m_v = 0; m_phase = 3; end
    end else if (m_phase == 1) begin
      if (rv) begin m_pc = rt; m_ins = NOP; m_v = 0; end
      else if (!s) begin
        if (m_pc % 4 != 0 || m_pc / 4 >= 128) begin
          m_f = 1; m_ins = NOP; m_v = 0; m_phase = 3;
        end else begin
          w = mem[m_pc / 4];
          m_ipc = m_pc; m_ins = w; m_v = 1; m_cnt = m_cnt + 1;
          if (w == EBRK) m_phase = 2; else m_pc = m_pc + 4;
        end
      end
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rt);
    snap_t e;
    reset = r; stall = s; redirect_valid = rv; redirect_target = rt;
    @(posedge clk);
    model_edge(r, s, rv, rt);
    e.pc = m_pc; e.ipc = m_ipc; e.ins = m_ins; e.cnt = m_cnt; e.v = m_v; e.h = m_phase == 3; e.f = m_f;
    q.push_back(e);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      snap_t e;
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("imem_address", imem_address, {2'b00, e.pc[31:2]});
      chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.v});
      chk("if_id_instruction", if_id_instruction, e.ins);
      if (e.v) chk("if_id_pc", if_id_pc, e.ipc);
      chk("halted", {31'd0, halted}, {31'd0, e.h});
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.f});
      chk("fetch_count", fetch_count, e.cnt);
    end
  end
  task automatic fill_nop;
    for (int i = 0; i < 128; i++) mem[i] = NOP;
    mem[0] = 32'h0050_0093; mem[1] = 32'h0010_8113; mem[2] = 32'h0020_81B3; mem[3] = NOP;
  endtask
  initial begin
    fill_nop();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h20);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    mem[5] = EBRK;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h40);
    cyc(0, 1, 1, 32'h44);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 32'h40);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h202);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h200);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'h8);
    for (int i = 0; i < 128; i++) mem[i] = $urandom_range(0, 31) == 0 ? EBRK : $urandom;
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, s, rv;
      logic [31:0] rt;
      int k;
      k = $urandom_range(0, 19);
      rt = k == 0 ? {$urandom_range(0, 255), 2'b00} : k == 1 ? $urandom : {23'd0, $urandom_range(0, 127), 2'b00};
      r = (halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0;
      s = $urandom_range(0, 3) == 0;
      rv = $urandom_range(0, 9) == 0;
      cyc(r, s, rv, rt);
    end
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
